decode_pipe_stage: RTL

Registered RV32 decode stage placed between fetch and execute, with valid/ready handshakes on both sides. It decodes the instruction, generates the immediate and control signals, and captures them in an ID/EX output register.
- An accepted JAL issues an early redirect to fetch.
- Wrong-path beats are then squashed until fetch presents the redirect target.
- Execute-side flush and illegal-opcode flagging are handled here.

---
 rtl/decode_pkg.sv | 45 ++++
 rtl/decode_pipe_stage_if.sv | 41 ++++
 rtl/decode_logic.sv | 81 ++++++++
 rtl/decode_pipe_stage.sv | 116 +++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared types for the decode stage: ISA enums, drain FSM state and the ID/EX payload.
package decode_pkg;

  typedef enum logic [6:0] {
    OPC_LUI      = 7'b0110111,
    OPC_AUIPC    = 7'b0010111,
    OPC_JAL      = 7'b1101111,
    OPC_JALR     = 7'b1100111,
    OPC_BRANCH   = 7'b1100011,
    OPC_LOAD     = 7'b0000011,
    OPC_STORE    = 7'b0100011,
    OPC_OP_IMM   = 7'b0010011,
    OPC_OP       = 7'b0110011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_e;

  typedef enum logic [4:0] {
    X0,  X1,  X2,  X3,  X4,  X5,  X6,  X7,  X8,  X9,  X10, X11, X12, X13, X14, X15,
    X16, X17, X18, X19, X20, X21, X22, X23, X24, X25, X26, X27, X28, X29, X30, X31
  } register_e;

  typedef enum logic [1:0] {ALU_A_RS1, ALU_A_PC, ALU_A_ZERO} alu_operand_a_e;
  typedef enum logic       {ALU_B_RS2, ALU_B_IMM} alu_operand_b_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} writeback_source_e;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} immediate_e;

  typedef enum logic {RUN, DRAIN} drain_state_e;

  // Everything the ID/EX register captures, so one assignment moves a whole beat.
  typedef struct packed {
    logic [31:0]       pc;
    register_e         rs1;
    register_e         rs2;
    register_e         rd;
    alu_operand_a_e    alu_a;
    alu_operand_b_e    alu_b;
    logic [31:0]       imm;
    logic              jump;
    writeback_source_e wb_sel;
    logic              we;
    logic              illegal;
  } decode_payload_t;

endpackage

// File: rtl/decode_pipe_stage_if.sv
// Fetch-side, execute-side and redirect signals of the decode stage.
interface decode_pipe_stage_if;
  import decode_pkg::*;

  logic              in_valid_i;
  logic              in_ready_o;
  logic [31:0]       in_pc_i;
  logic [31:0]       in_instruction_i;
  logic              flush_i;
  logic              redirect_valid_o;
  logic [31:0]       redirect_target_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [31:0]       out_pc_o;
  register_e         rs1_address_o;
  register_e         rs2_address_o;
  register_e         rd_address_o;
  alu_operand_a_e    alu_operand_a_selector_o;
  alu_operand_b_e    alu_operand_b_selector_o;
  logic [31:0]       immediate_o;
  logic              jump_o;
  writeback_source_e writeback_source_selector_o;
  logic              write_enable_o;
  logic              illegal_o;

  modport slave (
    input  in_valid_i, in_pc_i, in_instruction_i, flush_i, out_ready_i,
    output in_ready_o, redirect_valid_o, redirect_target_o, out_valid_o, out_pc_o,
           rs1_address_o, rs2_address_o, rd_address_o, alu_operand_a_selector_o,
           alu_operand_b_selector_o, immediate_o, jump_o, writeback_source_selector_o,
           write_enable_o, illegal_o
  );

  modport master (
    output in_valid_i, in_pc_i, in_instruction_i, flush_i, out_ready_i,
    input  in_ready_o, redirect_valid_o, redirect_target_o, out_valid_o, out_pc_o,
           rs1_address_o, rs2_address_o, rd_address_o, alu_operand_a_selector_o,
           alu_operand_b_selector_o, immediate_o, jump_o, writeback_source_selector_o,
           write_enable_o, illegal_o
  );
endinterface

// File: rtl/decode_logic.sv
// Combinational RV32 decode: control signals, immediate generation, illegal-opcode check.
module decode_logic
  import decode_pkg::*;
#(
  parameter bit EARLY_JUMP = 1'b1
) (
  input  logic [31:0]     pc_i,
  input  logic [31:0]     instruction_i,
  output decode_payload_t payload_o,
  output logic            is_jal_o
);
  opcode_e        opc;
  immediate_e     imm_sel;
  logic [31:0]    imm;
  logic           legal;
  logic           we;
  logic           jump;
  alu_operand_a_e alu_a;
  alu_operand_b_e alu_b;
  writeback_source_e wb_sel;

  assign opc      = opcode_e'(instruction_i[6:0]);
  assign is_jal_o = (opc == OPC_JAL);

  // Control unit: per-opcode operand, writeback and immediate selection.
  always_comb begin
    legal   = 1'b1;
    we      = 1'b0;
    jump    = 1'b0;
    alu_a   = ALU_A_RS1;
    alu_b   = ALU_B_RS2;
    wb_sel  = WB_ALU;
    imm_sel = IMM_NONE;
    case (opc)
      OPC_LUI:    begin imm_sel = IMM_U; alu_a = ALU_A_ZERO; alu_b = ALU_B_IMM; we = 1'b1; end
      OPC_AUIPC:  begin imm_sel = IMM_U; alu_a = ALU_A_PC;   alu_b = ALU_B_IMM; we = 1'b1; end
      // A JAL taken early in decode only needs its link written downstream.
      OPC_JAL:    begin imm_sel = IMM_J; alu_a = ALU_A_PC; alu_b = ALU_B_IMM; wb_sel = WB_PC4;
                        we = 1'b1; jump = !EARLY_JUMP; end
      OPC_JALR:   begin imm_sel = IMM_I; alu_b = ALU_B_IMM; wb_sel = WB_PC4; we = 1'b1; jump = 1'b1; end
      OPC_BRANCH: imm_sel = IMM_B;
      OPC_LOAD:   begin imm_sel = IMM_I; alu_b = ALU_B_IMM; wb_sel = WB_MEM; we = 1'b1; end
      OPC_STORE:  begin imm_sel = IMM_S; alu_b = ALU_B_IMM; end
      OPC_OP_IMM: begin imm_sel = IMM_I; alu_b = ALU_B_IMM; we = 1'b1; end
      OPC_OP:     we = 1'b1;
      OPC_MISC_MEM, OPC_SYSTEM: ;
      default:    legal = 1'b0;
    endcase
  end

  // Immediate generator: sign-extended per format.
  always_comb begin
    imm = 32'h0;
    case (imm_sel)
      IMM_I:   imm = {{20{instruction_i[31]}}, instruction_i[31:20]};
      IMM_S:   imm = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
      IMM_B:   imm = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                      instruction_i[30:25], instruction_i[11:8], 1'b0};
      IMM_U:   imm = {instruction_i[31:12], 12'h0};
      IMM_J:   imm = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                      instruction_i[20], instruction_i[30:21], 1'b0};
      default: imm = 32'h0;
    endcase
  end

  // Payload assembly; illegal beats travel as inert NOPs carrying the flag.
  always_comb begin
    payload_o         = '0;
    payload_o.pc      = pc_i;
    payload_o.rs1     = register_e'(instruction_i[19:15]);
    payload_o.rs2     = register_e'(instruction_i[24:20]);
    payload_o.rd      = register_e'(instruction_i[11:7]);
    payload_o.alu_a   = alu_a;
    payload_o.alu_b   = alu_b;
    payload_o.wb_sel  = wb_sel;
    payload_o.imm     = legal ? imm : 32'h0;
    payload_o.jump    = legal && jump;
    payload_o.we      = legal && we && (instruction_i[11:7] != 5'd0);
    payload_o.illegal = !legal;
  end
endmodule

// File: rtl/decode_pipe_stage.sv
// Decode stage: handshake, ID/EX register and the early-JAL drain FSM.
module decode_pipe_stage
  import decode_pkg::*;
#(
  parameter bit EARLY_JUMP    = 1'b1,
  parameter int DRAIN_TIMEOUT = 8
) (
  input logic          clk_i,
  input logic          rst_i,
  decode_pipe_stage_if.slave bus
);
  localparam int CW = (DRAIN_TIMEOUT > 2) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_TIMEOUT - 1);

  decode_payload_t dec, pay_q, pay_d;
  drain_state_e    state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     target_q, target_d;
  logic            out_valid_q, out_valid_d;
  logic            redir_q, redir_d;
  logic            pend_q, pend_d;
  logic            is_jal, accept, fwd, early, want;

  decode_logic #(.EARLY_JUMP(EARLY_JUMP)) u_dec (
    .pc_i          (bus.in_pc_i),
    .instruction_i (bus.in_instruction_i),
    .payload_o     (dec),
    .is_jal_o      (is_jal)
  );

  assign bus.in_ready_o = !bus.flush_i && (!out_valid_q || bus.out_ready_i);
  assign accept = bus.in_valid_i && bus.in_ready_o;
  // In DRAIN only the redirect target is allowed through; wrong-path beats are eaten.
  assign fwd    = accept && ((state_q == RUN) || (bus.in_pc_i == target_q));
  assign early  = EARLY_JUMP && fwd && is_jal && !dec.illegal;

  // Next-state: ID/EX capture, drain tracking and redirect pulse generation.
  always_comb begin
    pay_d       = pay_q;
    out_valid_d = out_valid_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    target_d    = target_q;
    redir_d     = 1'b0;
    pend_d      = 1'b0;
    want        = 1'b0;
    if (bus.flush_i) begin
      out_valid_d = 1'b0;
      state_d     = RUN;
      cnt_d       = '0;
    end else begin
      if (fwd) begin
        pay_d       = dec;
        out_valid_d = 1'b1;
      end else if (bus.out_ready_i) begin
        out_valid_d = 1'b0;
      end
      if (early) begin
        state_d  = DRAIN;
        cnt_d    = '0;
        target_d = bus.in_pc_i + dec.imm;
        want     = 1'b1;
      end else if (state_q == DRAIN) begin
        if (fwd) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          want  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // A request colliding with a pulse already on the wire slips one cycle.
      want    = want || pend_q;
      redir_d = want && !redir_q;
      pend_d  = want && redir_q;
    end
  end

  // State and ID/EX registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pay_q       <= '0;
      out_valid_q <= 1'b0;
      state_q     <= RUN;
      cnt_q       <= '0;
      target_q    <= '0;
      redir_q     <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      pay_q       <= pay_d;
      out_valid_q <= out_valid_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      target_q    <= target_d;
      redir_q     <= redir_d;
      pend_q      <= pend_d;
    end
  end

  assign bus.redirect_valid_o            = redir_q;
  assign bus.redirect_target_o           = target_q;
  assign bus.out_valid_o                 = out_valid_q;
  assign bus.out_pc_o                    = pay_q.pc;
  assign bus.rs1_address_o               = pay_q.rs1;
  assign bus.rs2_address_o               = pay_q.rs2;
  assign bus.rd_address_o                = pay_q.rd;
  assign bus.alu_operand_a_selector_o    = pay_q.alu_a;
  assign bus.alu_operand_b_selector_o    = pay_q.alu_b;
  assign bus.immediate_o                 = pay_q.imm;
  assign bus.jump_o                      = pay_q.jump;
  assign bus.writeback_source_selector_o = pay_q.wb_sel;
  assign bus.write_enable_o              = pay_q.we;
  assign bus.illegal_o                   = pay_q.illegal;
endmodule
